// File: rtl/fpu_host_sequencer_if.sv
// rtl/fpu_host_sequencer_if.sv - host request/response and FPU byte-bus signals
interface fpu_host_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opy;
  logic [31:0] opx;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic        FPUsel;
  logic [1:0]  addr;
  logic        read;
  logic        write;
  logic [7:0]  dataout;
  logic [7:0]  datain;

  modport master (
    input  start, op, opy, opx, datain,
    output busy, done, err, result, FPUsel, addr, read, write, dataout
  );

  modport slave (
    output start, op, opy, opx, datain,
    input  busy, done, err, result, FPUsel, addr, read, write, dataout
  );
endinterface

// File: rtl/fpu_host_sequencer.sv
// rtl/fpu_host_sequencer.sv - runs one FP operation on the byte-wide FPU peripheral
module fpu_host_sequencer #(
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic               clk,
  input  logic               reset,
  fpu_host_sequencer_if.master bus
);
  localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_Y, S_VAL_Y, S_CMD_X, S_VAL_X, S_CMD_OP, S_POLL, S_READ, S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic          gap_q, gap_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   opy_q, opy_d;
  logic [31:0]   opx_q, opx_d;
  logic [1:0]    op_q, op_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          stat_q, stat_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   result_q, result_d;
  logic          err_q, err_d;

  logic          sel_c, rd_c, wr_c;
  logic [1:0]    addr_c;
  logic [7:0]    dout_c;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      gap_q    <= 1'b0;
      idx_q    <= 2'd0;
      opy_q    <= '0;
      opx_q    <= '0;
      op_q     <= 2'd0;
      poll_q   <= '0;
      stat_q   <= 1'b0;
      shadow_q <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      opy_q    <= opy_d;
      opx_q    <= opx_d;
      op_q     <= op_d;
      poll_q   <= poll_d;
      stat_q   <= stat_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Every non-idle state except FIN is a two-cycle slot: access (gap_q=0), then idle gap.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    opy_d    = opy_q;
    opx_d    = opx_q;
    op_d     = op_q;
    poll_d   = poll_q;
    stat_d   = stat_q;
    shadow_d = shadow_q;
    result_d = result_q;
    err_d    = err_q;
    sel_c    = 1'b0;
    rd_c     = 1'b0;
    wr_c     = 1'b0;
    addr_c   = 2'b00;
    dout_c   = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          opy_d   = bus.opy;
          opx_d   = bus.opx;
          op_d    = bus.op;
          err_d   = 1'b0;
          gap_d   = 1'b0;
          idx_d   = 2'd0;
          poll_d  = '0;
          state_d = S_CMD_Y;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: begin
        if (!gap_q) begin
          gap_d = 1'b1;
          sel_c = 1'b1;
          case (state_q)
            S_CMD_Y:  begin wr_c = 1'b1; addr_c = 2'b10; dout_c = 8'h01; end
            S_VAL_Y:  begin wr_c = 1'b1; addr_c = 2'b11; dout_c = byte_of(opy_q, idx_q); end
            S_CMD_X:  begin wr_c = 1'b1; addr_c = 2'b10; dout_c = 8'h02; end
            S_VAL_X:  begin wr_c = 1'b1; addr_c = 2'b11; dout_c = byte_of(opx_q, idx_q); end
            S_CMD_OP: begin wr_c = 1'b1; addr_c = 2'b10; dout_c = {6'd0, op_q} + 8'd3; end
            S_POLL: begin
              rd_c   = 1'b1;
              addr_c = 2'b00;
              stat_d = bus.datain[7];
              poll_d = poll_q + PW'(1);
            end
            S_READ: begin
              rd_c   = 1'b1;
              addr_c = 2'b01;
              case (idx_q)
                2'd0:    shadow_d[31:24] = bus.datain;
                2'd1:    shadow_d[23:16] = bus.datain;
                2'd2:    shadow_d[15:8]  = bus.datain;
                default: shadow_d[7:0]   = bus.datain;
              endcase
            end
            default: ;
          endcase
        end else begin
          gap_d = 1'b0;
          case (state_q)
            S_CMD_Y:  begin state_d = S_VAL_Y; idx_d = 2'd0; end
            S_VAL_Y:  begin
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) state_d = S_CMD_X;
            end
            S_CMD_X:  begin state_d = S_VAL_X; idx_d = 2'd0; end
            S_VAL_X:  begin
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) state_d = S_CMD_OP;
            end
            S_CMD_OP: state_d = S_POLL;
            S_POLL: begin
              if (!stat_q) begin
                state_d = S_READ;
                idx_d   = 2'd0;
              end else if (poll_q == PW'(POLL_LIMIT)) begin
                state_d = S_FIN;
                err_d   = 1'b1;
              end
            end
            S_READ: begin
              idx_d = idx_q + 2'd1;
              if (idx_q == 2'd3) begin
                state_d  = S_FIN;
                result_d = shadow_q;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_FIN);
  assign bus.err     = err_q;
  assign bus.result  = result_q;
  assign bus.FPUsel  = sel_c;
  assign bus.read    = rd_c;
  assign bus.write   = wr_c;
  assign bus.addr    = addr_c;
  assign bus.dataout = dout_c;
endmodule

// File: tb/tb_fpu_host_sequencer.sv
// tb/tb_fpu_host_sequencer.sv - directed bench with behavioural FPU stub
module tb_fpu_host_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fpu_host_sequencer_if ifc ();

  fpu_host_sequencer #(.POLL_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FPU: busy 3 cycles after an op command, result bytes MSB first.
  logic        stuck = 1'b0;
  logic        tgt_x = 1'b0;
  logic [31:0] fy = '0, fx = '0, fres = '0;
  int          fcnt = 0;
  int          oidx = 0;

  function automatic logic [31:0] fpu_ref(input logic [7:0] cmd, input logic [31:0] y, input logic [31:0] x);
    if (cmd == 8'h04 && y == 32'h40400000 && x == 32'h40000000) return 32'h40C00000;
    if (cmd == 8'h06 && y == 32'h40A00000 && x == 32'h40400000) return 32'h40000000;
    if (cmd == 8'h03 && y == 32'h40C00000 && x == 32'h40000000) return 32'h40400000;
    if (cmd == 8'h05 && y == 32'h3F800000 && x == 32'h3F800000) return 32'h40000000;
    return 32'hFFFFFFFF;
  endfunction

  always @(posedge clk) begin
    if (fcnt != 0) fcnt <= fcnt - 1;
    if (ifc.FPUsel && ifc.write && ifc.addr == 2'b10) begin
      if (ifc.dataout == 8'h01) tgt_x <= 1'b0;
      else if (ifc.dataout == 8'h02) tgt_x <= 1'b1;
      else begin
        fres <= fpu_ref(ifc.dataout, fy, fx);
        fcnt <= 3;
        oidx <= 0;
      end
    end else if (ifc.FPUsel && ifc.write && ifc.addr == 2'b11) begin
      if (tgt_x) fx <= {fx[23:0], ifc.dataout};
      else       fy <= {fy[23:0], ifc.dataout};
    end else if (ifc.FPUsel && ifc.read && ifc.addr == 2'b01) begin
      oidx <= oidx + 1;
    end
  end

  logic [31:0] fres_sh;
  assign fres_sh    = fres << (8 * oidx);
  assign ifc.datain = (ifc.addr == 2'b00) ? {(stuck || fcnt != 0), 7'd0} : fres_sh[31:24];

  // Bus monitor
  logic [7:0] wbytes[$];
  int rd0 = 0, rd1 = 0, viol = 0, cmdop_cyc = 0, s0 = 0;
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    if (ifc.FPUsel) begin
      if (ifc.write) wbytes.push_back(ifc.dataout);
      if (ifc.write && ifc.addr == 2'b10 && ifc.dataout >= 8'h03) cmdop_cyc = cyc;
      if (ifc.read && ifc.addr == 2'b00) rd0++;
      if (ifc.read && ifc.addr == 2'b01) rd1++;
    end
    if ((ifc.read || ifc.write) && prev_strobe) viol++;
    prev_strobe = ifc.read || ifc.write;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [7:0] mul_trace [11] = '{8'h01, 8'h40, 8'h40, 8'h00, 8'h00, 8'h02,
                                 8'h40, 8'h00, 8'h00, 8'h00, 8'h04};

  task automatic check_mul_trace(input string tag);
    check({tag, "_len"}, wbytes.size(), 11);
    if (wbytes.size() == 11)
      for (int i = 0; i < 11; i++) check($sformatf("%s_b%0d", tag, i), wbytes[i], mul_trace[i]);
  endtask

  // Called at #1 into an IDLE cycle; returns at #1 into the done cycle.
  task automatic run(input logic [31:0] y, input logic [31:0] x, input logic [1:0] o,
                     input bit inject, output int done_rel);
    int n;
    wbytes.delete();
    rd0 = 0;
    rd1 = 0;
    ifc.opy = y; ifc.opx = x; ifc.op = o;
    ifc.start = 1'b1;
    s0 = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.opy = 32'h12345678; ifc.opx = 32'h9ABCDEF0; ifc.op = 2'd2;
    check("busy_c1", ifc.busy, 1);
    check("err_clr_c1", ifc.err, 0);
    n = 0;
    while (!ifc.done && n < 200) begin
      if (inject) begin
        ifc.start = (cyc - s0 == 10);
        ifc.opy = 32'h40A00000; ifc.opx = 32'h40400000; ifc.op = 2'd3;
      end
      @(posedge clk); #1;
      n++;
    end
    ifc.start = 1'b0;
    if (!ifc.done) check("done_wait", 0, 1);
    done_rel = cyc - s0;
  endtask

  int d;

  initial begin
    ifc.start = 1'b0; ifc.op = 2'd0; ifc.opy = '0; ifc.opx = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", {ifc.busy, ifc.done, ifc.err, ifc.FPUsel, ifc.read, ifc.write}, 0);
    check("rst_addr_data", {ifc.addr, ifc.dataout}, 0);
    check("rst_result", ifc.result, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Multiply 3.0 * 2.0
    run(32'h40400000, 32'h40000000, 2'd1, 1'b0, d);
    check_mul_trace("mul_trace");
    check("mul_cmdop_cyc", cmdop_cyc - s0, 21);
    check("mul_result", ifc.result, 32'h40C00000);
    check("mul_err", ifc.err, 0);
    check("mul_done_cyc", d, 35);
    check("mul_rd1", rd1, 4);
    @(posedge clk); #1;
    check("idle_after_done", ifc.busy, 0);

    // Subtract 5.0 - 3.0
    run(32'h40A00000, 32'h40400000, 2'd3, 1'b0, d);
    check("sub_cmd", (wbytes.size() == 11) ? wbytes[10] : 8'hxx, 8'h06);
    check("sub_result", ifc.result, 32'h40000000);
    check("no_b2b_strobe", viol, 0);
    @(posedge clk); #1;

    // Poll timeout
    stuck = 1'b1;
    run(32'h40400000, 32'h40000000, 2'd1, 1'b0, d);
    check("to_rd0", rd0, 4);
    check("to_rd1", rd1, 0);
    check("to_err", ifc.err, 1);
    check("to_result_kept", ifc.result, 32'h40000000);
    check("to_done_cyc", d, 31);
    stuck = 1'b0;
    @(posedge clk); #1;
    check("to_err_hold", ifc.err, 1);

    // Start while busy is ignored
    run(32'h40400000, 32'h40000000, 2'd1, 1'b1, d);
    check_mul_trace("sbusy_trace");
    check("sbusy_result", ifc.result, 32'h40C00000);
    check("sbusy_done_cyc", d, 35);
    @(posedge clk); #1;

    // Reset during VAL_X
    ifc.opy = 32'h3F800000; ifc.opx = 32'h3F800000; ifc.op = 2'd2;
    ifc.start = 1'b1;
    s0 = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    while (cyc - s0 < 15) begin @(posedge clk); #1; end
    check("rst_pre_sel", {ifc.FPUsel, ifc.write, ifc.addr}, 4'b1111);
    reset = 1'b1;
    #1;
    check("rst_mid_bus", {ifc.FPUsel, ifc.read, ifc.write, ifc.addr, ifc.dataout}, 0);
    check("rst_mid_busy", ifc.busy, 0);
    check("rst_mid_result", ifc.result, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Divide 6.0 / 2.0, then start during FIN
    run(32'h40C00000, 32'h40000000, 2'd0, 1'b0, d);
    check("div_cmd", (wbytes.size() == 11) ? wbytes[10] : 8'hxx, 8'h03);
    check("div_result", ifc.result, 32'h40400000);
    check("div_done_cyc", d, 35);
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    check("fin_start_ignored", ifc.busy, 0);
    @(posedge clk); #1;

    // Timeout to set err, then back-to-back add
    stuck = 1'b1;
    run(32'h40C00000, 32'h40000000, 2'd0, 1'b0, d);
    check("to2_err", ifc.err, 1);
    check("to2_result_kept", ifc.result, 32'h40400000);
    stuck = 1'b0;
    @(posedge clk); #1;
    run(32'h3F800000, 32'h3F800000, 2'd2, 1'b0, d);
    check("b2b_result", ifc.result, 32'h40000000);
    check("b2b_err", ifc.err, 0);
    check("b2b_done_cyc", d, 35);
    check("no_b2b_strobe_end", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
